ps2_receiver: RTL and testbench

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver.sv | 158 +++++++++++++++
 tb/tb_ps2_receiver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches PS2_CLK, then shifts in
// 11-bit frames (start, 8 data LSB-first, odd parity, stop), flagging errors.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input  logic       CLK_40MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state, state_next;
  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [7:0]    shift, shift_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic          par, par_next;
  logic [TW-1:0] timer, timer_next;
  logic [7:0]    code_next;
  logic          valid_next, perr_next, ferr_next;

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= PS2_CLK;
      clk_sync  <= clk_meta;
      data_meta <= PS2_DATA;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync != clk_filt) begin
      if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Edge is taken in the same cycle the filtered clock commits to 0, so the
  // frame logic sees it 2+FILTER_LEN cycles after the pin.
  assign fall = clk_filt && !clk_sync && (filt_cnt == FILT_LAST);

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_next     = par;
    timer_next   = '0;
    code_next    = SCAN_CODE;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;

    if (state != IDLE) begin
      timer_next = timer + TW'(1);
    end

    if (fall) begin
      timer_next = '0;
      case (state)
        IDLE: begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next = {data_sync, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          par_next   = data_sync;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!data_sync) begin
            ferr_next = 1'b1;
          end else if (!(^{shift, par})) begin
            perr_next = 1'b1;
          end else begin
            code_next  = shift;
            valid_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && timer == TIME_LAST) begin
      state_next = IDLE;
      ferr_next  = 1'b1;
      timer_next = '0;
    end
  end

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      timer      <= '0;
      SCAN_CODE  <= '0;
      SCAN_VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      par        <= par_next;
      timer      <= timer_next;
      SCAN_CODE  <= code_next;
      SCAN_VALID <= valid_next;
      PARITY_ERR <= perr_next;
      FRAME_ERR  <= ferr_next;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: expected strobes are queued as frames are
// driven and matched by a monitor as the DUT raises them.
`timescale 1ns/1ps
module tb_ps2_receiver;

  localparam int unsigned F    = 8;
  localparam int unsigned T    = 8000;
  localparam int          HALF = 50;  // shortened PS/2 half-period keeps the run small

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_PERR  = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, parity_err, frame_err, busy;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   drop_cyc = 0;
  logic prev_any = 1'b0;
  exp_t exp_q[$];

  ps2_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .CLK_40MHZ (clk),
    .RESET     (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data),
    .SCAN_CODE (scan_code),
    .SCAN_VALID(scan_valid),
    .PARITY_ERR(parity_err),
    .FRAME_ERR (frame_err),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] kind;
    logic any;
    any = scan_valid | parity_err | frame_err;
    if (!rst && any) begin
      kind = scan_valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
      tests_run++;
      if ((32'(scan_valid) + 32'(parity_err) + 32'(frame_err)) > 1) begin
        tests_failed++;
        $display("FAIL one_hot_strobes: got valid=%b perr=%b ferr=%b, need at most one",
                 scan_valid, parity_err, frame_err);
      end
      tests_run++;
      if (prev_any) begin
        tests_failed++;
        $display("FAIL strobe_width: strobe high in consecutive cycles at cycle %0d, need one-cycle pulse", cyc);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: got kind=%0d code=%h, need no strobe", kind, scan_code);
      end else begin
        e = exp_q.pop_front();
        if (kind !== e.kind) begin
          tests_failed++;
          $display("FAIL strobe_kind: got kind=%0d, need kind=%0d", kind, e.kind);
        end else if (e.kind == K_VALID) begin
          tests_run++;
          if (scan_code !== e.code) begin
            tests_failed++;
            $display("FAIL scan_code: got %h, need %h", scan_code, e.code);
          end
        end
      end
    end
    prev_any = any && !rst;
  end

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      drop_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] c);
    exp_t e;
    e.kind = k;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    wait_cycles(4 * HALF);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drained: got %0d pending strobes, need 0", name, exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_busy_idle: got BUSY=%b, need 0", name, busy);
    end
  endtask

  task automatic check_code(input string name, input logic [7:0] want);
    tests_run++;
    if (scan_code !== want) begin
      tests_failed++;
      $display("FAIL %s_code_hold: got %h, need %h", name, scan_code, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({scan_code, scan_valid, parity_err, frame_err, busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got code=%h v=%b p=%b f=%b busy=%b, need all 0",
               scan_code, scan_valid, parity_err, frame_err, busy);
    end
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_valid();
    push(K_VALID, 8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 10);
    check_drained("valid");
    check_code("valid", 8'h1C);
  endtask

  task automatic test_back_to_back();
    push(K_VALID, 8'hF0);
    push(K_VALID, 8'h1C);
    send_bits(frame(8'hF0, 1'b1, 1'b1), 0, 10);
    send_bits(frame(8'h1C, odd_par(8'h1C), 1'b1), 0, 10);
    check_drained("b2b");
    check_code("b2b", 8'h1C);
  endtask

  task automatic test_bad_parity();
    push(K_PERR, 8'h00);
    send_bits(frame(8'h1C, 1'b1, 1'b1), 0, 10);
    check_drained("parity");
    check_code("parity", 8'h1C);
  endtask

  task automatic test_bad_stop();
    push(K_FERR, 8'h00);
    send_bits(frame(8'h29, odd_par(8'h29), 1'b0), 0, 10);
    push(K_FERR, 8'h00);
    send_bits(frame(8'h29, ~odd_par(8'h29), 1'b0), 0, 10);
    check_drained("stop");
    check_code("stop", 8'h1C);
  endtask

  task automatic test_timeout();
    int seen;
    seen = -1;
    push(K_FERR, 8'h00);
    send_bits(frame(8'h29, 1'b0, 1'b1), 0, 4);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (frame_err && seen < 0) seen = cyc;
    end
    tests_run++;
    if (seen < 0) begin
      tests_failed++;
      $display("FAIL timeout_strobe: got no FRAME_ERR within 10000 cycles, need one");
    end else if (seen - drop_cyc != int'(2 + F + T)) begin
      tests_failed++;
      $display("FAIL timeout_latency: got %0d cycles from pin edge, need %0d",
               seen - drop_cyc, 2 + F + T);
    end
    check_drained("timeout");
    push(K_VALID, 8'h29);
    send_bits(frame(8'h29, odd_par(8'h29), 1'b1), 0, 10);
    check_drained("after_timeout");
    check_code("after_timeout", 8'h29);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic test_glitch();
    logic [10:0] f;
    glitch();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_idle: got BUSY=%b, need 0", busy);
    end
    f = frame(8'hA5, odd_par(8'hA5), 1'b1);
    push(K_VALID, 8'hA5);
    send_bits(f, 0, 3);
    glitch();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_midframe: got BUSY=%b, need 1", busy);
    end
    send_bits(f, 4, 10);
    check_drained("glitch");
    check_code("glitch", 8'hA5);
  endtask

  task automatic test_reset_mid_frame();
    send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 5);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({scan_code, scan_valid, parity_err, frame_err, busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got code=%h v=%b p=%b f=%b busy=%b, need all 0",
               scan_code, scan_valid, parity_err, frame_err, busy);
    end
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2 * HALF);
    check_drained("midreset");
    push(K_VALID, 8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 10);
    check_drained("after_reset");
    check_code("after_reset", 8'h1C);
  endtask

  initial begin
    test_reset();
    test_valid();
    test_back_to_back();
    test_bad_parity();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
